// File: rtl/vertex_matrix_sequencer.sv
// ---------------------------------------------------------------------------
// vertex_matrix_sequencer
//
// Holds the vertex stage's current 4x4 transform matrix M and a small
// push/pop stack of saved matrices. Compose commands (translate, scale,
// rotate) build a sparse matrix T and compute M = M*T through a single
// 16x16 multiply-accumulate unit, one product per cycle (64 cycles per
// compose), followed by a one-edge commit.
//
// Ports:
//   I_CLOCK       rising-edge clock
//   I_RESET_N     synchronous active-low reset
//   I_Valid       command valid
//   I_Cmd[2:0]    0 NOP, 1 LOADIDENTITY, 2 PUSH, 3 POP, 4 TRANSLATE,
//                 5 SCALE, 6 ROTATE, 7 reserved (NOP)
//   I_Operand     [31:16] x / cos, [47:32] y / sin, remaining bits unused
//   I_FRAMESTALL  freezes all state and blocks command acceptance
//   O_Ready       command can be accepted this cycle
//   O_Busy        compose in progress (COMPUTE or COMMIT)
//   O_Done        one-cycle pulse after a compose result is committed
//   O_Error       one-cycle pulse after push-when-full / pop-when-empty
//   O_Depth       current stack occupancy
//   O_Matrix      committed matrix, element (r,c) at bits 16*(4r+c) +: 16
//   O_State       debug view of the sequencer state (0 IDLE, 1 COMPUTE,
//                 2 COMMIT)
//
// Handshake: a command is taken at a rising edge where I_Valid && O_Ready;
// O_Ready = IDLE && !I_FRAMESTALL. I_Cmd/I_Operand are only looked at on
// that edge, so the source may change them freely afterwards.
// STACK_DEPTH must be at least 2.
// ---------------------------------------------------------------------------
module vertex_matrix_sequencer #(
    parameter int STACK_DEPTH = 4,
    parameter int DEPTH_W     = 3,
    parameter int FRAC_BITS   = 0
) (
    input  logic               I_CLOCK,
    input  logic               I_RESET_N,
    input  logic               I_Valid,
    input  logic [2:0]         I_Cmd,
    input  logic [63:0]        I_Operand,
    input  logic               I_FRAMESTALL,
    output logic               O_Ready,
    output logic               O_Busy,
    output logic               O_Done,
    output logic               O_Error,
    output logic [DEPTH_W-1:0] O_Depth,
    output logic [255:0]       O_Matrix,
    output logic [1:0]         O_State
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_COMMIT  = 2'd2
    } state_t;

    localparam logic [2:0] CMD_LOADID    = 3'd1;
    localparam logic [2:0] CMD_PUSH      = 3'd2;
    localparam logic [2:0] CMD_POP       = 3'd3;
    localparam logic [2:0] CMD_TRANSLATE = 3'd4;
    localparam logic [2:0] CMD_SCALE     = 3'd5;
    localparam logic [2:0] CMD_ROTATE    = 3'd6;

    localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    // Diagonal elements (0,0),(1,1),(2,2),(3,3) sit at element indices
    // 0, 5, 10, 15.
    localparam logic [255:0] IDENTITY = {16'd1, 64'd0, 16'd1, 64'd0,
                                         16'd1, 64'd0, 16'd1};

    state_t              r_state;
    state_t              w_next_state;
    logic [255:0]        r_m;
    logic [255:0]        r_t;
    logic [255:0]        r_r;
    logic [255:0]        r_stack [STACK_DEPTH];
    logic [DEPTH_W-1:0]  r_depth;
    logic [5:0]          r_cnt;
    logic signed [31:0]  r_acc;
    logic                r_done;
    logic                r_error;

    logic                w_ready;
    logic                w_accept;
    logic                w_is_compose;
    logic                w_full;
    logic                w_empty;
    logic [DEPTH_W-1:0]  w_depth_m1;
    logic [PTR_W-1:0]    w_push_idx;
    logic [PTR_W-1:0]    w_pop_idx;
    logic [255:0]        w_t_new;
    logic [3:0]          w_m_idx;
    logic [3:0]          w_t_idx;
    logic signed [15:0]  w_m_elem;
    logic signed [15:0]  w_t_elem;
    logic signed [31:0]  w_prod;
    logic signed [31:0]  w_acc_next;
    logic                w_unused_operand;

    assign w_ready      = (r_state == S_IDLE) && !I_FRAMESTALL;
    assign w_accept     = I_Valid && w_ready;
    assign w_is_compose = (I_Cmd == CMD_TRANSLATE) || (I_Cmd == CMD_SCALE) ||
                          (I_Cmd == CMD_ROTATE);
    assign w_full       = (r_depth == DEPTH_W'(STACK_DEPTH));
    assign w_empty      = (r_depth == '0);
    assign w_depth_m1   = r_depth - DEPTH_W'(1);
    assign w_push_idx   = r_depth[PTR_W-1:0];
    assign w_pop_idx    = w_depth_m1[PTR_W-1:0];

    assign w_unused_operand = ^{I_Operand[63:48], I_Operand[15:0]};

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_compose) begin
                    w_next_state = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (!I_FRAMESTALL && (r_cnt == 6'd63)) begin
                    w_next_state = S_COMMIT;
                end
            end
            S_COMMIT: begin
                if (!I_FRAMESTALL) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // ---------------- T matrix for the incoming compose ----------------
    always_comb begin
        w_t_new = IDENTITY;
        case (I_Cmd)
            CMD_TRANSLATE: begin
                w_t_new[48  +: 16] = I_Operand[31:16];   // T03
                w_t_new[112 +: 16] = I_Operand[47:32];   // T13
            end
            CMD_SCALE: begin
                w_t_new[0  +: 16] = I_Operand[31:16];    // T00
                w_t_new[80 +: 16] = I_Operand[47:32];    // T11
            end
            CMD_ROTATE: begin
                w_t_new[0  +: 16] = I_Operand[31:16];            // T00 = cos
                w_t_new[80 +: 16] = I_Operand[31:16];            // T11 = cos
                w_t_new[16 +: 16] = I_Operand[47:32];            // T01 = sin
                w_t_new[64 +: 16] = 16'd0 - I_Operand[47:32];    // T10 = -sin
            end
            default: w_t_new = IDENTITY;
        endcase
    end

    // ---------------- shared MAC ----------------
    // cnt = {i, j, k}: M index is 4i+k, T index is 4k+j.
    assign w_m_idx    = {r_cnt[5:4], r_cnt[1:0]};
    assign w_t_idx    = {r_cnt[1:0], r_cnt[3:2]};
    assign w_m_elem   = r_m[{w_m_idx, 4'b0000} +: 16];
    assign w_t_elem   = r_t[{w_t_idx, 4'b0000} +: 16];
    assign w_prod     = w_m_elem * w_t_elem;
    assign w_acc_next = ((r_cnt[1:0] == 2'd0) ? 32'sd0 : r_acc) + w_prod;

    // ---------------- state and datapath registers ----------------
    always_ff @(posedge I_CLOCK) begin
        if (!I_RESET_N) begin
            r_state <= S_IDLE;
            r_m     <= IDENTITY;
            r_t     <= IDENTITY;
            r_r     <= '0;
            r_depth <= '0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (I_Cmd)
                            CMD_LOADID: r_m <= IDENTITY;
                            CMD_PUSH: begin
                                if (!w_full) begin
                                    r_depth <= r_depth + DEPTH_W'(1);
                                end else begin
                                    r_error <= 1'b1;
                                end
                            end
                            CMD_POP: begin
                                if (!w_empty) begin
                                    r_m     <= r_stack[w_pop_idx];
                                    r_depth <= w_depth_m1;
                                end else begin
                                    r_error <= 1'b1;
                                end
                            end
                            CMD_TRANSLATE, CMD_SCALE, CMD_ROTATE: begin
                                r_t   <= w_t_new;
                                r_cnt <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_COMPUTE: begin
                    if (!I_FRAMESTALL) begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt[1:0] == 2'd3) begin
                            r_r[{r_cnt[5:2], 4'b0000} +: 16] <= w_acc_next[FRAC_BITS +: 16];
                        end
                    end
                end
                S_COMMIT: begin
                    if (!I_FRAMESTALL) begin
                        r_m    <= r_r;
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stack storage is not reset; only the pointer defines what is valid.
    always_ff @(posedge I_CLOCK) begin
        if (I_RESET_N && w_accept && (I_Cmd == CMD_PUSH) && !w_full) begin
            r_stack[w_push_idx] <= r_m;
        end
    end

    assign O_Ready  = w_ready;
    assign O_Busy   = (r_state != S_IDLE);
    assign O_Done   = r_done;
    assign O_Error  = r_error;
    assign O_Depth  = r_depth;
    assign O_Matrix = r_m;
    assign O_State  = r_state;

endmodule

// File: tb/tb_vertex_matrix_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vertex_matrix_sequencer
//
// Directed scenarios plus a randomized command stream. A reference model
// (plain 4x4 integer matrix arithmetic and an array stack) predicts the
// matrix/depth/pulse seen after every command; predictions go into exp_q
// and a monitor pops and compares whenever the DUT presents a result
// (O_Done, O_Error, or the cycle after a non-compose command is taken).
// ---------------------------------------------------------------------------
module tb_vertex_matrix_sequencer;

    localparam int STACK_DEPTH = 4;
    localparam int DEPTH_W     = 3;
    localparam int FRAC_BITS   = 0;
    localparam int TIMEOUT     = 400;

    localparam logic [1:0] K_QUIET = 2'd0;
    localparam logic [1:0] K_DONE  = 2'd1;
    localparam logic [1:0] K_ERROR = 2'd2;

    logic               I_CLOCK;
    logic               I_RESET_N;
    logic               I_Valid;
    logic [2:0]         I_Cmd;
    logic [63:0]        I_Operand;
    logic               I_FRAMESTALL;
    logic               O_Ready;
    logic               O_Busy;
    logic               O_Done;
    logic               O_Error;
    logic [DEPTH_W-1:0] O_Depth;
    logic [255:0]       O_Matrix;
    logic [1:0]         O_State;

    vertex_matrix_sequencer #(
        .STACK_DEPTH (STACK_DEPTH),
        .DEPTH_W     (DEPTH_W),
        .FRAC_BITS   (FRAC_BITS)
    ) dut (
        .I_CLOCK      (I_CLOCK),
        .I_RESET_N    (I_RESET_N),
        .I_Valid      (I_Valid),
        .I_Cmd        (I_Cmd),
        .I_Operand    (I_Operand),
        .I_FRAMESTALL (I_FRAMESTALL),
        .O_Ready      (O_Ready),
        .O_Busy       (O_Busy),
        .O_Done       (O_Done),
        .O_Error      (O_Error),
        .O_Depth      (O_Depth),
        .O_Matrix     (O_Matrix),
        .O_State      (O_State)
    );

    // ---------------- clock / reset ----------------
    initial I_CLOCK = 1'b0;
    always #5 I_CLOCK = ~I_CLOCK;

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic [1:0]   kind;
        logic [255:0] m;
        logic [2:0]   depth;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // ---------------- reference model ----------------
    logic [15:0] mm [16];
    logic [15:0] mstk [STACK_DEPTH][16];
    int          mdepth;

    function automatic logic [255:0] identity_m();
        logic [255:0] p;
        p = '0;
        for (int d = 0; d < 4; d++) p[16*(5*d) +: 16] = 16'd1;
        return p;
    endfunction

    function automatic logic [255:0] pack_model();
        logic [255:0] p;
        for (int e = 0; e < 16; e++) p[16*e +: 16] = mm[e];
        return p;
    endfunction

    function automatic void model_identity();
        for (int e = 0; e < 16; e++) mm[e] = (e % 5 == 0) ? 16'd1 : 16'd0;
    endfunction

    function automatic logic [63:0] mk_op(input logic [15:0] x, input logic [15:0] y);
        return {16'h0000, y, x, 16'h0000};
    endfunction

    // M = M * T with T derived from the command's operand.
    function automatic void model_compose(input logic [2:0] cmd, input logic [63:0] op);
        logic [15:0] t [16];
        logic [15:0] r [16];
        logic [31:0] acc;
        for (int e = 0; e < 16; e++) t[e] = (e % 5 == 0) ? 16'd1 : 16'd0;
        if (cmd == 3'd4) begin
            t[3] = op[31:16];  t[7] = op[47:32];
        end else if (cmd == 3'd5) begin
            t[0] = op[31:16];  t[5] = op[47:32];
        end else begin
            t[0] = op[31:16];  t[5] = op[31:16];
            t[1] = op[47:32];  t[4] = 16'd0 - op[47:32];
        end
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                acc = 0;
                for (int k = 0; k < 4; k++) begin
                    acc = acc + 32'($signed(mm[4*i+k]) * $signed(t[4*k+j]));
                end
                acc = acc >> FRAC_BITS;
                r[4*i+j] = acc[15:0];
            end
        end
        for (int e = 0; e < 16; e++) mm[e] = r[e];
    endfunction

    function automatic void model_apply(input logic [2:0] cmd, input logic [63:0] op);
        exp_t x;
        x.kind = K_QUIET;
        case (cmd)
            3'd1: model_identity();
            3'd2: begin
                if (mdepth < STACK_DEPTH) begin
                    for (int e = 0; e < 16; e++) mstk[mdepth][e] = mm[e];
                    mdepth++;
                end else x.kind = K_ERROR;
            end
            3'd3: begin
                if (mdepth > 0) begin
                    mdepth--;
                    for (int e = 0; e < 16; e++) mm[e] = mstk[mdepth][e];
                end else x.kind = K_ERROR;
            end
            3'd4, 3'd5, 3'd6: begin
                model_compose(cmd, op);
                x.kind = K_DONE;
            end
            default: ;
        endcase
        x.m     = pack_model();
        x.depth = 3'(mdepth);
        exp_q.push_back(x);
    endfunction

    // ---------------- comparison helper ----------------
    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    logic       mon_acc = 1'b0;
    logic [2:0] mon_cmd = 3'd0;

    always @(posedge I_CLOCK) begin
        mon_acc <= I_Valid && O_Ready && I_RESET_N;
        mon_cmd <= I_Cmd;
    end

    initial begin
        forever begin
            @(negedge I_CLOCK);
            if (O_Done || O_Error ||
                (mon_acc && !(mon_cmd inside {3'd4, 3'd5, 3'd6}))) begin
                logic [1:0] act_kind;
                exp_t x;
                act_kind = O_Done ? (O_Error ? 2'd3 : K_DONE) : (O_Error ? K_ERROR : K_QUIET);
                if (exp_q.size() == 0) begin
                    check("unexpected_result", {254'd0, act_kind}, 256'h1ff);
                end else begin
                    x = exp_q.pop_front();
                    check("result_kind", {254'd0, act_kind}, {254'd0, x.kind});
                    check("result_matrix", O_Matrix, x.m);
                    check("result_depth", {253'd0, O_Depth}, {253'd0, x.depth});
                    check("result_busy", {255'd0, O_Busy}, 256'd0);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [2:0] cmd, input logic [63:0] op,
                        input bit stall_en, input bit expect_it);
        bit ok;
        int waited;
        ok = 0;
        waited = 0;
        while (!ok && waited < TIMEOUT) begin
            @(negedge I_CLOCK);
            I_FRAMESTALL = stall_en ? ($urandom_range(0, 3) == 0) : 1'b0;
            #1;
            if (O_Ready) begin
                I_Valid   = 1'b1;
                I_Cmd     = cmd;
                I_Operand = op;
                ok = 1;
            end
            waited++;
        end
        if (!ok) begin
            check("send_ready_timeout", 256'd0, 256'd1);
            I_FRAMESTALL = 1'b0;
            return;
        end
        @(posedge I_CLOCK);
        #1;
        // Scramble the command inputs: the DUT must have latched them.
        I_Valid   = 1'b0;
        I_Cmd     = 3'($urandom);
        I_Operand = {$urandom, $urandom};
        if (expect_it) model_apply(cmd, op);
    endtask

    // Counts falling edges after the accept edge until O_Done is seen;
    // stalls edges accept+stall_from .. accept+stall_from+stall_len-1.
    task automatic wait_done(input int stall_from, input int stall_len,
                             output int n_lat, output int n_notready);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        n_notready = 0;
        I_FRAMESTALL = 1'b0;
        while (!seen && n < TIMEOUT) begin
            @(negedge I_CLOCK);
            n++;
            if (!O_Ready) n_notready++;
            if (O_Done) seen = 1;
            else I_FRAMESTALL = (n >= stall_from) && (n < stall_from + stall_len);
        end
        I_FRAMESTALL = 1'b0;
        n_lat = seen ? n : -1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        I_FRAMESTALL = 1'b0;
        do begin
            @(negedge I_CLOCK);
            #1;
            n++;
        end while (!O_Ready && n < TIMEOUT);
        if (!O_Ready) check("idle_timeout", 256'd0, 256'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int nr;
        logic [255:0] saved;

        I_RESET_N    = 1'b0;
        I_Valid      = 1'b0;
        I_Cmd        = 3'd0;
        I_Operand    = '0;
        I_FRAMESTALL = 1'b0;
        model_identity();
        mdepth = 0;
        repeat (3) @(posedge I_CLOCK);
        @(negedge I_CLOCK);
        I_RESET_N = 1'b1;
        #1;

        // Reset state
        check("rst_matrix", O_Matrix, identity_m());
        check("rst_depth", {253'd0, O_Depth}, 256'd0);
        check("rst_busy", {255'd0, O_Busy}, 256'd0);
        check("rst_done", {255'd0, O_Done}, 256'd0);
        check("rst_error", {255'd0, O_Error}, 256'd0);
        check("rst_ready", {255'd0, O_Ready}, 256'd1);
        check("rst_state", {254'd0, O_State}, 256'd0);

        // 1: translate latency and result
        send(3'd4, mk_op(16'd3, 16'd5), 0, 1);
        wait_done(1000, 0, lat, nr);
        check("t1_latency", 256'(lat), 256'd66);
        check("t1_notready_cycles", 256'(nr), 256'd65);
        check("t1_m03", {240'd0, O_Matrix[48 +: 16]}, 256'd3);
        check("t1_m13", {240'd0, O_Matrix[112 +: 16]}, 256'd5);

        // 2: scale after translate
        send(3'd5, mk_op(16'd2, 16'd4), 0, 1);
        wait_idle();
        check("t2_m00", {240'd0, O_Matrix[0 +: 16]}, 256'd2);
        check("t2_m11", {240'd0, O_Matrix[80 +: 16]}, 256'd4);
        check("t2_m03", {240'd0, O_Matrix[48 +: 16]}, 256'd3);
        check("t2_m13", {240'd0, O_Matrix[112 +: 16]}, 256'd5);

        // 3: push / translate / pop restores identity
        send(3'd1, 64'd0, 0, 1);
        send(3'd2, 64'd0, 0, 1);
        send(3'd4, mk_op(16'd7, 16'd9), 0, 1);
        send(3'd3, 64'd0, 0, 1);
        wait_idle();
        check("t3_matrix", O_Matrix, identity_m());
        check("t3_depth", {253'd0, O_Depth}, 256'd0);

        // 4: overflow and underflow
        for (int i = 0; i < 5; i++) send(3'd2, 64'd0, 0, 1);
        wait_idle();
        check("t4_depth_full", {253'd0, O_Depth}, 256'd4);
        for (int i = 0; i < 5; i++) send(3'd3, 64'd0, 0, 1);
        wait_idle();
        check("t4_depth_empty", {253'd0, O_Depth}, 256'd0);

        // 5: rotate by 90 degrees, without and with a 10-cycle stall
        send(3'd1, 64'd0, 0, 1);
        send(3'd6, mk_op(16'd0, 16'd1), 0, 1);
        wait_done(1000, 0, lat, nr);
        check("t5_latency", 256'(lat), 256'd66);
        check("t5_m10", {240'd0, O_Matrix[64 +: 16]}, 256'hffff);
        saved = O_Matrix;
        send(3'd1, 64'd0, 0, 1);
        send(3'd6, mk_op(16'd0, 16'd1), 0, 1);
        wait_done(20, 10, lat, nr);
        check("t5_stall_latency", 256'(lat), 256'd76);
        check("t5_stall_matrix", O_Matrix, saved);

        // 6: reset in the middle of a scale
        send(3'd2, 64'd0, 0, 1);
        send(3'd5, mk_op(16'd2, 16'd2), 0, 0);
        repeat (30) @(posedge I_CLOCK);
        @(negedge I_CLOCK);
        I_RESET_N = 1'b0;
        @(negedge I_CLOCK);
        I_RESET_N = 1'b1;
        model_identity();
        mdepth = 0;
        #1;
        check("t6_matrix", O_Matrix, identity_m());
        check("t6_busy", {255'd0, O_Busy}, 256'd0);
        check("t6_state", {254'd0, O_State}, 256'd0);
        check("t6_ready", {255'd0, O_Ready}, 256'd1);
        check("t6_depth", {253'd0, O_Depth}, 256'd0);
        repeat (80) @(negedge I_CLOCK);

        // 7: random command stream with random stalls
        for (int n = 0; n < 60; n++) begin
            logic [2:0]  cmd;
            logic [63:0] op;
            cmd = 3'($urandom_range(0, 7));
            op  = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) op = mk_op(16'($urandom_range(0, 7)), 16'($urandom_range(0, 7)));
            send(cmd, op, $urandom_range(0, 1) == 1, 1);
        end
        wait_idle();
        repeat (3) @(negedge I_CLOCK);
        check("queue_drained", 256'(exp_q.size()), 256'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vertex_matrix_sequencer.md
Name: vertex_matrix_sequencer

Overview:
Owns the vertex stage's current 4x4 transform matrix and its push/pop matrix stack. It sequences every matrix-compose operation (translate, scale, rotate) through one shared 16x16 multiply-accumulate unit, one product per cycle, instead of 64 parallel multipliers. It sits between fetch/decode and the vertex transform datapath. The datapath reads the committed matrix from O_Matrix.

Parameters:
STACK_DEPTH, 4, number of matrix-stack entries (each entry is 256 bits).
DEPTH_W, 3, width of O_Depth; must hold the value STACK_DEPTH.
FRAC_BITS, 0, fixed-point fraction bits; each element result is acc[FRAC_BITS+15:FRAC_BITS].

Ports:
I_CLOCK  in  1  clock; all state updates on the rising edge.
I_RESET_N  in  1  reset; synchronous, active-low.
I_Valid  in  1  command valid.
I_Cmd  in  3  command: 0 NOP, 1 LOADIDENTITY, 2 PUSH, 3 POP, 4 TRANSLATE, 5 SCALE, 6 ROTATE, 7 reserved (treated as NOP).
I_Operand  in  64  [31:16] is x/cos; [47:32] is y/sin; other bits are ignored.
I_FRAMESTALL  in  1  freezes the sequencer and blocks command acceptance.
O_Ready  out  1  command can be accepted this cycle.
O_Busy  out  1  state is COMPUTE or COMMIT.
O_Done  out  1  one-cycle pulse in the cycle after a compose commits.
O_Error  out  1  one-cycle pulse on push-when-full or pop-when-empty.
O_Depth  out  DEPTH_W  current stack occupancy.
O_Matrix  out  256  current matrix; element (r,c) is at bits [16*(4r+c)+15 : 16*(4r+c)].

Behaviour:
- Reset (I_RESET_N=0 at a clock edge):
  - M = identity (diagonal elements 1, all others 0); stack pointer 0; state IDLE.
  - O_Done=0, O_Error=0, O_Busy=0.
  - Reset overrides everything, including a compose in progress; the partial result is discarded.
- Handshake:
  - O_Ready = (state==IDLE) && !I_FRAMESTALL.
  - A command is accepted at a clock edge when I_Valid && O_Ready.
  - I_Cmd and I_Operand are latched at acceptance; later changes to them are ignored.
- States: IDLE, COMPUTE, COMMIT.
- IDLE, command accepted:
  - NOP/reserved: no effect.
  - LOADIDENTITY: M = identity at the accept edge.
  - PUSH:
    - If depth < STACK_DEPTH: stack[depth] = M, depth = depth+1.
    - Else: O_Error=1 next cycle; M and stack unchanged.
  - POP:
    - If depth > 0: M = stack[depth-1], depth = depth-1.
    - Else: O_Error=1 next cycle; M unchanged.
  - TRANSLATE/SCALE/ROTATE: build T and go to COMPUTE with counter cnt=0.
- T matrix: starts as identity, then overridden by the command:
  - TRANSLATE: T03 = op[31:16], T13 = op[47:32].
  - SCALE: T00 = op[31:16], T11 = op[47:32].
  - ROTATE: T00 = T11 = op[31:16], T01 = op[47:32], T10 = two's-complement negation of op[47:32].
- COMPUTE:
  - Computes R = M*T.
  - Element index e = cnt[5:2], with i = e/4 and j = e%4; term index k = cnt[1:0].
  - Each cycle: acc = (k==0 ? 0 : acc) + signed(M[i][k]) * signed(T[k][j]); acc is 32-bit signed and wraps.
  - When k==3: R[e] = acc_next[FRAC_BITS+15:FRAC_BITS].
  - cnt increments each non-stalled cycle; after cnt==63 is processed, the state goes to COMMIT.
  - M is not modified during COMPUTE; O_Matrix holds the old value.
- COMMIT: one edge that performs M = R, sets O_Done=1 for the following cycle, and returns to IDLE.
- Latency (no stall): accept at edge t; COMPUTE covers edges t+1 to t+64; COMMIT at edge t+65. The new O_Matrix and O_Done=1 are visible after edge t+65, and O_Ready is high again in that same cycle.
- I_FRAMESTALL=1: cnt, acc, state, M and stack all hold, and no command is accepted. Each stall cycle adds one cycle of latency.
- O_Done and O_Error are never asserted together; all commands other than the failing PUSH/POP leave O_Error at 0.
- O_Busy = (state != IDLE).

Test Plan:
1. Reset, then TRANSLATE op[31:16]=3, op[47:32]=5 -> O_Done 66 cycles after acceptance; M03=3, M13=5, diagonal=1, all other elements 0; O_Ready low for exactly 65 cycles after the accept edge.
2. TRANSLATE(3,5) then SCALE(2,4) -> M00=2, M11=4, M03=3, M13=5, M22=M33=1.
3. PUSH, TRANSLATE(7,9), POP -> O_Depth goes 1, then 0; M returns to identity; no O_Error.
4. With STACK_DEPTH=4: five PUSHes -> O_Depth=4 and O_Error pulses once, on the 5th. POP four times, then a fifth POP -> O_Error pulses once, O_Depth=0, M unchanged.
5. ROTATE with cos=0, sin=1 applied to identity -> M00=0, M01=1, M10=0xFFFF, M11=0. Holding I_FRAMESTALL for 10 cycles mid-compute -> O_Done arrives 76 cycles after acceptance, with the same result.
6. Assert I_RESET_N=0 at cnt=30 of a SCALE(2,2) -> M=identity, state IDLE, O_Done never pulses; O_Ready=1 the cycle after reset is released.
